serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, LSB-first full subtractor: computes `din_a - din_b - b_in` over `WIDTH` clock cycles using one difference/borrow bit-slice and a borrow flip-flop. It is the subtracting counterpart to the team's combinational full-adder bit-slice. It sits alongside that slice as the area-lean arithmetic unit for datapaths that can tolerate multi-cycle latency. Operation uses a start/busy/done handshake; the result is held until the next accepted start.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `din_a`  in  WIDTH  minuend; sampled on the accepting edge only.
- `din_b`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `b_in`  in  1  borrow-in; sampled on the accepting edge only.
- `busy`  out  1  high while in RUN.
- `done`  out  1  single-cycle pulse when the result becomes valid.
- `dout`  out  WIDTH  difference, modulo 2^WIDTH.
- `b_out`  out  1  final borrow; 1 iff unsigned `din_a < din_b + b_in`.

## Operation
FSM states and transitions:
- **IDLE**: `start=1` moves to RUN; otherwise stays in IDLE.
- **RUN**: stays in RUN while bit counter < WIDTH-1; moves to DONE after the WIDTH-th bit.
- **DONE**: lasts one cycle. `start=1` moves to RUN (back-to-back operation); otherwise moves to IDLE.

Accept edge (IDLE/DONE with `start=1`):
- Load shift registers `sa <= din_a` and `sb <= din_b`.
- Set borrow register `br <= b_in`.
- Set bit counter `cnt <= 0`.
- Leave `dout` and `b_out` unchanged.

Each RUN edge processes bit i = `cnt`:
- Difference bit: `d = sa[0] ^ sb[0] ^ br`.
- Borrow update: `br <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`.
- Shift `sa` and `sb` right by one.
- Shift `d` into the MSB of internal result register `res` (right shift). After WIDTH shifts, bit i sits at `res[i]`.
- Increment `cnt`.

Last RUN edge (`cnt == WIDTH-1`):
- Load `dout` with the completed result, i.e. `{d, res[WIDTH-1:1]}`.
- Load `b_out` with the new borrow value.
- Move to DONE.

`start` while in RUN is ignored: no restart, and operands are not resampled. Input changes during RUN have no effect.

Arithmetic: `dout = (din_a - din_b - b_in) mod 2^WIDTH`. `{b_out, dout}` equals the (WIDTH+1)-bit two's-complement result of `din_a - din_b - b_in` with unsigned operands.

`WIDTH = 1` degenerates to a single RUN cycle with the same behaviour.

Counter width is `$clog2(WIDTH)` with a minimum of 1 bit. No counter wrap occurs within an operation.

## Timing
- All outputs are registered. Reset values: `busy=0`, `done=0`, `dout=0`, `b_out=0`; FSM in IDLE; `sa`, `sb`, `res`, `br` and `cnt` all 0.
- Latency: take the accepting edge as E. Then `busy=1` from after E through E+WIDTH. `done=1` and `dout`/`b_out` are valid in the cycle after edge E+WIDTH, which is WIDTH cycles after acceptance.
- `done` is high for exactly one cycle per operation. `busy` and `done` are never high together.
- `dout` and `b_out` hold their values until the next completion or reset.
- Back-to-back: `start=1` during DONE is accepted on that edge. `busy` rises in the next cycle with no idle gap, so throughput is one result per WIDTH+1 cycles.
- Reset mid-operation: `rst=1` on any edge forces every output and all state to reset values on that edge. `rst` has priority over `start`. The aborted operation never asserts `done`.

## Test plan
- `WIDTH=8`, `din_a=0x35`, `din_b=0x12`, `b_in=0` → `done` exactly 8 cycles after the accepting edge; `dout=0x23`, `b_out=0`; `busy` high for exactly 8 cycles.
- `din_a=0x12`, `din_b=0x35`, `b_in=0` → `dout=0xDD`, `b_out=1`. Then `0x00 - 0x00` with `b_in=1` → `dout=0xFF`, `b_out=1`. Then `0xFF - 0xFF` with `b_in=0` → `dout=0x00`, `b_out=0`.
- Start `0x80 - 0x01`, then pulse `start` with `din_a=0x00`, `din_b=0x00` on RUN cycles 2 and 5 → both pulses ignored; result `dout=0x7F`, `b_out=0`; single `done` pulse.
- Start `0xAA - 0x55`, assert `rst` for one cycle on RUN cycle 4 → next cycle `busy=0`, `done=0`, `dout=0x00`, `b_out=0`; no `done` afterwards. A new start of `0x10 - 0x01` then yields `dout=0x0F`.
- Back-to-back: `0x0A - 0x03` completes; `start` held high during DONE with `0x03 - 0x0A` → `busy` rises the next cycle; first result `0x07`/`b_out=0`, second `0xF9`/`b_out=1`; `done` pulses 9 cycles apart.
- Randomized: 200 operands at `WIDTH=8`, plus `WIDTH=1` exhaustive (8 cases) → `{b_out, dout}` matches a reference model of `din_a - din_b - b_in` for every operation.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial, LSB-first full subtractor. Computes din_a - din_b - b_in over
// WIDTH clock cycles. A single difference/borrow bit-slice is reused on every
// cycle, and a flip-flop carries the borrow from one bit to the next.
// Handshake: start is accepted in IDLE or DONE. busy is high while bits are
// being processed. done pulses for one cycle when dout/b_out become valid.
// The result is held until the next completion or reset.
//
// Ports:
//   clk    : clock, rising-edge active
//   rst    : synchronous active-high reset
//   start  : operation request (ignored while busy)
//   din_a  : minuend, sampled on the accepting edge
//   din_b  : subtrahend, sampled on the accepting edge
//   b_in   : borrow-in, sampled on the accepting edge
//   busy   : high while the operation is running
//   done   : one-cycle pulse, result valid
//   dout   : difference modulo 2^WIDTH
//   b_out  : final borrow (din_a < din_b + b_in, unsigned)
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din_a,
   input  logic [WIDTH-1:0] din_b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic             b_out
);

   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] sa, sb, res, res_next;
   logic [CW-1:0]    cnt;
   logic             br, br_next, d;
   logic             accept, last;

   assign last = (cnt == LAST);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and outputs. busy/done decode the state register only,
   // so both come straight from flops.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Difference/borrow bit-slice on the current LSBs.
   // The new difference bit enters res at the MSB. After WIDTH shifts,
   // bit i sits at res[i]. Writing the MSB after the shift keeps this
   // valid for WIDTH = 1.
   always_comb begin
      d                 = sa[0] ^ sb[0] ^ br;
      br_next           = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      res_next          = res >> 1;
      res_next[WIDTH-1] = d;
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         sa    <= '0;
         sb    <= '0;
         res   <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         dout  <= '0;
         b_out <= 1'b0;
      end else if (accept) begin
         sa  <= din_a;
         sb  <= din_b;
         br  <= b_in;
         cnt <= '0;
      end else if (state == RUN) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         br  <= br_next;
         res <= res_next;
         cnt <= cnt + CW'(1);
         if (last) begin
            dout  <= res_next;
            b_out <= br_next;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor.
// Two instances are exercised: WIDTH=8 and WIDTH=1. Drivers push expected
// {b_out, dout} values and the accept cycle into per-instance queues.
// Monitors pop an entry on every done pulse and compare the result and
// the latency.
module tb_serial_subtractor;

   typedef struct {
      logic [8:0]  exp;
      int unsigned acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0, bin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bout8;
   logic [7:0] dout8;

   logic       start1 = 1'b0, bin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy1, done1, bout1;
   logic [0:0] dout1;

   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned passes = 0;
   int unsigned done_cnt8 = 0, done_cnt1 = 0;
   int unsigned done_cyc8 = 0, done_prev8 = 0;
   int unsigned busy_run8 = 0, busy_run1 = 0;
   exp_t        q8[$];
   exp_t        q1[$];

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .din_a(a8), .din_b(b8), .b_in(bin8),
      .busy(busy8), .done(done8), .dout(dout8), .b_out(bout8)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .din_a(a1), .din_b(b1), .b_in(bin1),
      .busy(busy1), .done(done1), .dout(dout1), .b_out(bout1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor for the WIDTH=8 instance
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done8) begin
            done_cnt8++;
            done_prev8 = done_cyc8;
            done_cyc8  = cyc;
            check("busy_done_exclusive8", busy8, 0);
            check("busy_length8", busy_run8, 8);
            check("done_expected8", q8.size() != 0, 1);
            if (q8.size() != 0) begin
               e = q8.pop_front();
               check("result8", {bout8, dout8}, e.exp);
               check("latency8", cyc - e.acc, 8);
            end
            busy_run8 = 0;
         end else if (busy8) begin
            busy_run8++;
         end else begin
            busy_run8 = 0;
         end
      end else begin
         busy_run8 = 0;
      end
   end

   // Monitor for the WIDTH=1 instance
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done1) begin
            done_cnt1++;
            check("busy_done_exclusive1", busy1, 0);
            check("busy_length1", busy_run1, 1);
            check("done_expected1", q1.size() != 0, 1);
            if (q1.size() != 0) begin
               e = q1.pop_front();
               check("result1", {7'b0, bout1, dout1}, e.exp);
               check("latency1", cyc - e.acc, 1);
            end
            busy_run1 = 0;
         end else if (busy1) begin
            busy_run1++;
         end else begin
            busy_run1 = 0;
         end
      end else begin
         busy_run1 = 0;
      end
   end

   // Called at a negedge. It returns at the negedge after the accepting edge.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi);
      int unsigned n = 0;
      logic [8:0]  r;
      while (busy8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("issue_wait8", busy8, 0);
      r = {1'b0, a} - {1'b0, b} - {8'b0, bi};
      a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
      q8.push_back('{exp: r, acc: cyc + 1});
      @(negedge clk);
      start8 = 1'b0;
      // Scramble the operands after acceptance. The DUT must not resample them.
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
   endtask

   task automatic issue1(input logic a, input logic b, input logic bi);
      int unsigned n = 0;
      logic [1:0]  r;
      while (busy1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("issue_wait1", busy1, 0);
      r = {1'b0, a} - {1'b0, b} - {1'b0, bi};
      a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
      q1.push_back('{exp: {7'b0, r}, acc: cyc + 1});
      @(negedge clk);
      start1 = 1'b0;
      a1 = ~a; b1 = ~b; bin1 = ~bi;
   endtask

   task automatic drain8();
      int unsigned n = 0;
      while ((q8.size() != 0 || busy8) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout8", q8.size(), 0);
      @(negedge clk);
   endtask

   task automatic drain1();
      int unsigned n = 0;
      while ((q1.size() != 0 || busy1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout1", q1.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      int unsigned dc;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_busy8", busy8, 0);
      check("reset_done8", done8, 0);
      check("reset_dout8", dout8, 0);
      check("reset_bout8", bout8, 0);
      check("reset_busy1", busy1, 0);
      check("reset_dout1", {bout1, dout1}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic operation, latency and hold
      issue8(8'h35, 8'h12, 1'b0);
      drain8();
      check("t1_dout", dout8, 8'h23);
      check("t1_bout", bout8, 0);
      repeat (3) @(negedge clk);
      check("t1_hold", {bout8, dout8}, 9'h023);

      // Borrow cases
      issue8(8'h12, 8'h35, 1'b0);
      issue8(8'h00, 8'h00, 1'b1);
      issue8(8'hFF, 8'hFF, 1'b0);
      drain8();
      check("t2_final", {bout8, dout8}, 9'h000);

      // start during RUN is ignored (pulses on RUN cycles 2 and 5)
      dc = done_cnt8;
      issue8(8'h80, 8'h01, 1'b0);
      @(negedge clk); start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
      @(negedge clk); start8 = 1'b0;
      @(negedge clk);
      @(negedge clk); start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
      @(negedge clk); start8 = 1'b0;
      drain8();
      repeat (12) @(negedge clk);
      check("t3_single_done", done_cnt8 - dc, 1);
      check("t3_result", {bout8, dout8}, 9'h07F);

      // Reset during RUN cycle 4
      issue8(8'hAA, 8'h55, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      q8.delete();
      dc = done_cnt8;
      @(negedge clk);
      rst = 1'b0;
      check("t4_busy", busy8, 0);
      check("t4_done", done8, 0);
      check("t4_dout", dout8, 8'h00);
      check("t4_bout", bout8, 0);
      repeat (15) @(negedge clk);
      check("t4_no_done", done_cnt8 - dc, 0);
      issue8(8'h10, 8'h01, 1'b0);
      drain8();
      check("t4_restart", {bout8, dout8}, 9'h00F);

      // Back-to-back
      issue8(8'h0A, 8'h03, 1'b0);
      issue8(8'h03, 8'h0A, 1'b0);
      check("t5_busy_rise", busy8, 1);
      drain8();
      check("t5_second", {bout8, dout8}, 9'h1F9);
      check("t5_spacing", done_cyc8 - done_prev8, 9);

      // Random operands
      for (int i = 0; i < 200; i++) begin
         issue8(8'($urandom), 8'($urandom), 1'($urandom));
      end
      drain8();

      // WIDTH=1 exhaustive
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         issue1(v[2], v[1], v[0]);
      end
      drain1();
      check("w1_done_count", done_cnt1, 8);

      check("sb_empty8", q8.size(), 0);
      check("sb_empty1", q1.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
